uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//   Round-robin scheduler that shares one uart_tx transmitter between N_REQ byte sources.
//   Grants one requester per frame, drives uart_tx's i_uart_data / i_uart_en,
//   waits for o_uart_done, then enforces an idle gap before the next grant.
//   Sits between the byte producers and uart_tx; one instance per UART line.
// PARAMETERS
//   N_REQ          4      number of requesters (>=1)
//   GAP_CYCLES     16     idle clocks after each frame before next grant (0 = none)
//   TIMEOUT_CYCLES 65536  max clocks in BUSY without done before the frame is abandoned
// PORTS
//   clk           in   1         system clock, rising edge
//   rst_n         in   1         asynchronous active-low reset
//   i_req_valid   in   N_REQ     per-requester byte available; held until its o_req_ready pulse
//   i_req_data    in   8*N_REQ   byte of requester r at [8r+7:8r]
//   o_req_ready   out  N_REQ     one-hot, 1-cycle pulse: byte of that requester captured
//   o_tx_data     out  8         to uart_tx i_uart_data; held stable from grant until next grant
//   o_tx_en       out  1         to uart_tx i_uart_en; 1-cycle start pulse
//   i_tx_done     in   1         from uart_tx o_uart_done (level or pulse)
//   o_busy        out  1         1 whenever state != IDLE
//   o_grant_id    out  clog2(N)  index of last granted requester (0 when N_REQ=1)
//   o_timeout     out  1         1-cycle pulse when a frame is abandoned
//   o_frame_cnt   out  16        completed frames (done seen), wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, all outputs 0, RR pointer=0, counters 0; mid-frame reset aborts
//     the frame immediately, no ready/en/timeout pulse is emitted afterwards for it.
//   States: IDLE -> BUSY -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//   IDLE: at an edge with |i_req_valid, pick g = first valid index searching ptr, ptr+1, ... (mod N_REQ).
//     At that edge register: o_tx_data<=byte g, o_tx_en<=1, o_req_ready<=onehot(g), o_grant_id<=g,
//     ptr<=(g+1) mod N_REQ, state<=BUSY. So ready and en rise 1 cycle after valid is sampled, together.
//   Requester contract: byte is captured at the edge where o_req_ready rises; requester may drop valid
//     or present the next byte from the following edge. Valid is not sampled outside IDLE.
//   BUSY: o_tx_en, o_req_ready low. Completion = rising edge of i_tx_done (registered prior value);
//     a done level already high on BUSY entry does not count. On completion: o_frame_cnt++,
//     state<=GAP (or IDLE if GAP_CYCLES=0). Timeout counter counts BUSY cycles; when it reaches
//     TIMEOUT_CYCLES-1 without completion: o_timeout pulse, state<=IDLE, frame not counted.
//     Completion and timeout on the same edge: completion wins, no timeout pulse.
//   GAP: count GAP_CYCLES clocks, then IDLE. Requests arriving in BUSY/GAP wait; none are lost.
//   Fairness: with all requesters valid, grants rotate 0,1,..,N_REQ-1,0,...; an idle requester is
//     skipped without costing a cycle.
//   Widths: gap/timeout counters sized by $clog2 of their parameter; o_frame_cnt modulo 2^16.
// STRUCTURE
//   Shared package uart_pkg: state encoding (IDLE/BUSY/GAP), UART byte width (8), default timeout.
//   Sub-module uart_rr_arb: combinational round-robin pick (valid vector + pointer -> one-hot grant,
//     index, any). Scheduler FSM, counters and output registers stay in uart_tx_sched.
// TESTING (bench wraps uart_tx_sched + uart_tx, clk 50 MHz)
//   1 Reset: rst_n=0 with valid=4'b1111 -> all outputs 0, no o_tx_en; release -> first grant id 0.
//   2 Single req: valid[2]=1, data=8'hA5 -> one ready[2] pulse with o_tx_en, serial line shows 0xA5,
//     frame_cnt=1, next grant not earlier than GAP_CYCLES clocks after done.
//   3 All valid, bytes 8'h10..8'h13 held for 8 frames -> grant order 0,1,2,3,0,1,2,3; line bytes match.
//   4 Skip: valid=4'b1001 after grant 0 -> next grant 3, then 0; no extra idle cycles in arbitration.
//   5 Timeout: i_tx_done stuck 0 (model) -> o_timeout pulse exactly TIMEOUT_CYCLES after entry,
//     frame_cnt unchanged, next grant proceeds; done held high from before grant -> not counted.
//   6 Reset mid-frame: assert rst_n=0 during BUSY -> outputs 0 immediately; after release,
//     pending requester re-granted from ptr 0, frame_cnt restarts at 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the UART transmit scheduler
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int DEFAULT_TIMEOUT = 65536;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Counter/index width that stays at least one bit for degenerate parameters.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// rtl/uart_rr_arb.sv - combinational round-robin pick starting at a pointer
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // Search ptr, ptr+1, ... so a skipped idle requester costs no extra cycle.
    always_comb begin
        int j;
        j         = 0;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!any && valid[j]) begin
                any         = 1'b1;
                grant_idx   = IDX_W'(j);
                grant_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx between N byte sources
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int   N_REQ          = 4,
    parameter int   GAP_CYCLES     = 16,
    parameter int   TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    localparam int  IDX_W          = clog2_min1(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]             o_req_ready,
    output logic [UART_DATA_W-1:0]       o_tx_data,
    output logic                         o_tx_en,
    input  logic                         i_tx_done,
    output logic                         o_busy,
    output logic [IDX_W-1:0]             o_grant_id,
    output logic                         o_timeout,
    output logic [15:0]                  o_frame_cnt
);

    localparam int TCNT_W = clog2_min1(TIMEOUT_CYCLES);
    localparam int GCNT_W = clog2_min1(GAP_CYCLES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0]        ST_AFTER  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    logic [1:0]             state;
    logic [IDX_W-1:0]       ptr;
    logic [TCNT_W-1:0]      tcnt;
    logic [GCNT_W-1:0]      gcnt;
    logic                   done_q;
    logic                   done_rise;

    logic [N_REQ-1:0]       grant_oh;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [IDX_W-1:0]       ptr_next;
    logic [UART_DATA_W-1:0] sel_byte;

    uart_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .valid     (i_req_valid),
        .ptr       (ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (grant_oh[r]) begin
                sel_byte = i_req_data[UART_DATA_W*r +: UART_DATA_W];
            end
        end
    end

    assign ptr_next  = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    // A done level already high when the frame starts must not complete it.
    assign done_rise = i_tx_done & ~done_q;
    assign o_busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            done_q      <= 1'b0;
            o_req_ready <= '0;
            o_tx_data   <= '0;
            o_tx_en     <= 1'b0;
            o_grant_id  <= '0;
            o_timeout   <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_tx_en     <= 1'b0;
            o_req_ready <= '0;
            o_timeout   <= 1'b0;
            done_q      <= i_tx_done;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        o_tx_data   <= sel_byte;
                        o_tx_en     <= 1'b1;
                        o_req_ready <= grant_oh;
                        o_grant_id  <= grant_idx;
                        ptr         <= ptr_next;
                        tcnt        <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Completion takes priority over a timeout on the same edge.
                    if (done_rise) begin
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        gcnt        <= '0;
                        state       <= ST_AFTER;
                    end else if (tcnt == TCNT_LAST) begin
                        o_timeout <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gcnt == GCNT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt + GCNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int N_REQ   = 4;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_req_valid = '0;
    logic [31:0] i_req_data = '0;
    logic [3:0]  o_req_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_en;
    logic        i_tx_done = 1'b0;
    logic        o_busy;
    logic [1:0]  o_grant_id;
    logic        o_timeout;
    logic [15:0] o_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    always #10 clk = ~clk;

    uart_tx_sched #(
        .N_REQ          (N_REQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_en     (o_tx_en),
        .i_tx_done   (i_tx_done),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id),
        .o_timeout   (o_timeout),
        .o_frame_cnt (o_frame_cnt)
    );

    task automatic wait_en(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (o_tx_en === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int c;
        c  = 0;
        ok = (o_busy === 1'b0);
        while (!ok && c < limit) begin
            @(negedge clk);
            c++;
            if (o_busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int cyc;
        bit seen;
        bit ok;
        rst_n       = 1'b0;
        i_req_valid = 4'b1111;
        i_req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_tx_en, o_req_ready, o_busy, o_timeout, o_grant_id, o_tx_data, o_frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b rdy=%b busy=%b to=%b id=%0d data=%h cnt=%0d, all required 0",
                     o_tx_en, o_req_ready, o_busy, o_timeout, o_grant_id, o_tx_data, o_frame_cnt);
        end
        rst_n = 1'b1;
        wait_en(5, cyc, seen);
        n_checks++;
        if (!seen || cyc != 1) begin
            n_fail++;
            $display("FAIL reset_first_grant_latency: seen=%b cycles=%0d, required seen in 1", seen, cyc);
        end
        n_checks++;
        if (o_grant_id !== 2'd0 || o_req_ready !== 4'b0001 || o_tx_data !== 8'h10) begin
            n_fail++;
            $display("FAIL reset_first_grant: id=%0d rdy=%b data=%h, required 0/0001/10",
                     o_grant_id, o_req_ready, o_tx_data);
        end
        i_req_valid = '0;
        pulse_done();
        exp_frames = 1;
        n_checks++;
        if (o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL reset_frame_cnt: got %0d required %0d", o_frame_cnt, exp_frames);
        end
        wait_idle(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_single();
        int cyc;
        bit seen;
        bit ok;
        i_req_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        i_req_valid = 4'b0100;
        wait_en(20, cyc, seen);
        n_checks++;
        if (!seen || o_grant_id !== 2'd2 || o_req_ready !== 4'b0100 || o_tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_grant: seen=%b id=%0d rdy=%b data=%h, required 1/2/0100/a5",
                     seen, o_grant_id, o_req_ready, o_tx_data);
        end
        i_req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (o_tx_en !== 1'b0 || o_req_ready !== 4'b0000 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse_width: en=%b rdy=%b busy=%b, required 0/0000/1",
                     o_tx_en, o_req_ready, o_busy);
        end
        pulse_done();
        exp_frames++;
        n_checks++;
        if (o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL single_frame_cnt: got %0d required %0d", o_frame_cnt, exp_frames);
        end
        i_req_valid = 4'b0001;
        wait_en(30, cyc, seen);
        n_checks++;
        if (!seen || cyc != GAP + 1 || o_grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_gap: seen=%b cycles=%0d id=%0d, required 1/%0d/0", seen, cyc, o_grant_id, GAP + 1);
        end
        i_req_valid = '0;
        pulse_done();
        exp_frames++;
        wait_idle(20, ok);
        n_checks++;
        if (!ok || o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL single_end: idle=%b cnt=%0d, required 1/%0d", ok, o_frame_cnt, exp_frames);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        bit seen;
        bit ok;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
        apply_reset();
        exp_frames  = 0;
        i_req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        i_req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_id   = 2'(i % 4);
            exp_data = 8'(8'h10 + (i % 4));
            wait_en(30, cyc, seen);
            n_checks++;
            if (!seen || o_grant_id !== exp_id || o_tx_data !== exp_data) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: seen=%b id=%0d data=%h, required id=%0d data=%h",
                         i, seen, o_grant_id, o_tx_data, exp_id, exp_data);
            end
            pulse_done();
            exp_frames++;
        end
        i_req_valid = '0;
        wait_idle(20, ok);
        n_checks++;
        if (!ok || o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL rr_frame_cnt: idle=%b cnt=%0d, required 1/%0d", ok, o_frame_cnt, exp_frames);
        end
    endtask

    task automatic test_skip();
        int cyc;
        bit seen;
        bit ok;
        i_req_valid = 4'b1111;
        wait_en(10, cyc, seen);
        n_checks++;
        if (!seen || o_grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL skip_first: seen=%b id=%0d, required 1/0", seen, o_grant_id);
        end
        i_req_valid = 4'b1001;
        pulse_done();
        wait_en(30, cyc, seen);
        n_checks++;
        if (!seen || cyc != GAP + 1 || o_grant_id !== 2'd3 || o_tx_data !== 8'h13) begin
            n_fail++;
            $display("FAIL skip_to_3: seen=%b cycles=%0d id=%0d data=%h, required 1/%0d/3/13",
                     seen, cyc, o_grant_id, o_tx_data, GAP + 1);
        end
        pulse_done();
        wait_en(30, cyc, seen);
        n_checks++;
        if (!seen || cyc != GAP + 1 || o_grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL skip_wrap_0: seen=%b cycles=%0d id=%0d, required 1/%0d/0", seen, cyc, o_grant_id, GAP + 1);
        end
        i_req_valid = '0;
        pulse_done();
        exp_frames += 3;
        wait_idle(20, ok);
        n_checks++;
        if (!ok || o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL skip_frame_cnt: idle=%b cnt=%0d, required 1/%0d", ok, o_frame_cnt, exp_frames);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit seen;
        bit ok;
        i_req_valid = 4'b0010;
        wait_en(10, cyc, seen);
        n_checks++;
        if (!seen || o_grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL to_grant: seen=%b id=%0d, required 1/1", seen, o_grant_id);
        end
        i_req_valid = '0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < TIMEOUT + 10) begin
            @(negedge clk);
            cyc++;
            if (o_timeout === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || cyc != TIMEOUT) begin
            n_fail++;
            $display("FAIL to_pulse_time: seen=%b cycles=%0d, required 1/%0d", seen, cyc, TIMEOUT);
        end
        n_checks++;
        if (o_busy !== 1'b0 || o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL to_abandon: busy=%b cnt=%0d, required 0/%0d", o_busy, o_frame_cnt, exp_frames);
        end
        @(negedge clk);
        n_checks++;
        if (o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pulse_width: timeout=%b required 0", o_timeout);
        end
        i_tx_done = 1'b1;
        @(negedge clk);
        i_req_valid = 4'b0100;
        wait_en(10, cyc, seen);
        n_checks++;
        if (!seen || o_grant_id !== 2'd2 || o_tx_data !== 8'h12) begin
            n_fail++;
            $display("FAIL to_next_grant: seen=%b id=%0d data=%h, required 1/2/12", seen, o_grant_id, o_tx_data);
        end
        i_req_valid = '0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1 || o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL to_stale_done: busy=%b cnt=%0d, required 1/%0d", o_busy, o_frame_cnt, exp_frames);
        end
        i_tx_done = 1'b0;
        @(negedge clk);
        pulse_done();
        exp_frames++;
        n_checks++;
        if (o_frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL to_fresh_done: cnt=%0d required %0d", o_frame_cnt, exp_frames);
        end
        wait_idle(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL to_idle: busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        bit seen;
        bit stray;
        i_req_valid = 4'b1010;
        wait_en(10, cyc, seen);
        n_checks++;
        if (!seen || o_grant_id !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_pre_grant: seen=%b id=%0d, required 1/3", seen, o_grant_id);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_tx_en, o_req_ready, o_busy, o_timeout, o_grant_id, o_tx_data, o_frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: en=%b rdy=%b busy=%b to=%b id=%0d data=%h cnt=%0d, all required 0",
                     o_tx_en, o_req_ready, o_busy, o_timeout, o_grant_id, o_tx_data, o_frame_cnt);
        end
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_tx_en !== 1'b0 || o_req_ready !== 4'b0000 || o_timeout !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: stray pulse during reset, required none");
        end
        rst_n = 1'b1;
        wait_en(5, cyc, seen);
        n_checks++;
        if (!seen || cyc != 1 || o_grant_id !== 2'd1 || o_req_ready !== 4'b0010 || o_frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_regrant: seen=%b cycles=%0d id=%0d rdy=%b cnt=%0d, required 1/1/1/0010/0",
                     seen, cyc, o_grant_id, o_req_ready, o_frame_cnt);
        end
        i_req_valid = '0;
        pulse_done();
        n_checks++;
        if (o_frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_frame_cnt: cnt=%0d required 1", o_frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
